if_fetch_unit: RTL



---
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect inputs, instruction-memory port and IF/ID-facing outputs.
interface if_fetch_unit_if #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
);
    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   pc_out;
    logic              inst_valid;
    logic              if_id_en;

    modport slave (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_req, imem_addr, inst_out, pc_out, inst_valid, if_id_en
    );

    modport master (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, inst_out, pc_out, inst_valid, if_id_en
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and feeds IF/ID.
// Define FETCH_SKID_BUF_EN to park the stalled instruction in a skid buffer instead of refetching it.
module if_fetch_unit #(
    parameter int                PC_W     = 64,
    parameter int                INST_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic           clk,
    input  logic           arst,
    if_fetch_unit_if.slave bus_io
);
    // IDLE: post-reset, no request | RUN: fetching | HOLD: stalled, result parked or rewound
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              infl_v_q, infl_v_d;
    logic [PC_W-1:0]   infl_pc_q, infl_pc_d;
    logic              redirect;
    logic              pres_v;
    logic [INST_W-1:0] pres_inst;
    logic [PC_W-1:0]   pres_pc;

    assign redirect = bus_io.redirect_valid && (state_q != IDLE);

    assign bus_io.if_id_en   = !bus_io.stall || bus_io.redirect_valid;
    assign bus_io.imem_req   = (state_q != IDLE) && (redirect || !bus_io.stall);
    assign bus_io.imem_addr  = redirect ? bus_io.redirect_pc : pc_q;
    assign bus_io.inst_valid = pres_v && !redirect;
    assign bus_io.inst_out   = bus_io.inst_valid ? pres_inst : NOP_INST;
    assign bus_io.pc_out     = pres_pc;

`ifdef FETCH_SKID_BUF_EN
    logic              skid_v_q, skid_v_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            skid_v_q    <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    always_comb begin
        pres_v    = infl_v_q;
        pres_inst = bus_io.imem_rdata;
        pres_pc   = infl_pc_q;
        if (skid_v_q) begin
            pres_v    = 1'b1;
            pres_inst = skid_inst_q;
            pres_pc   = skid_pc_q;
        end
    end
`else
    assign pres_v    = infl_v_q;
    assign pres_inst = bus_io.imem_rdata;
    assign pres_pc   = infl_pc_q;
`endif

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            infl_v_q  <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            infl_v_q  <= infl_v_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        infl_v_d  = infl_v_q;
        infl_pc_d = infl_pc_q;
`ifdef FETCH_SKID_BUF_EN
        skid_v_d    = skid_v_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
`endif
        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (redirect) begin
            state_d   = RUN;
            pc_d      = bus_io.redirect_pc + PC_STEP;
            infl_v_d  = 1'b1;
            infl_pc_d = bus_io.redirect_pc;
`ifdef FETCH_SKID_BUF_EN
            skid_v_d  = 1'b0;
`endif
        end else if (bus_io.stall) begin
            state_d  = HOLD;
            infl_v_d = 1'b0;
`ifdef FETCH_SKID_BUF_EN
            if (infl_v_q) begin
                skid_v_d    = 1'b1;
                skid_inst_d = bus_io.imem_rdata;
                skid_pc_d   = infl_pc_q;
            end
`else
            // The returning instruction is dropped here and refetched once the stall clears.
            if (infl_v_q) begin
                pc_d = infl_pc_q;
            end
`endif
        end else begin
            state_d   = RUN;
            pc_d      = pc_q + PC_STEP;
            infl_v_d  = 1'b1;
            infl_pc_d = pc_q;
`ifdef FETCH_SKID_BUF_EN
            skid_v_d  = 1'b0;
`endif
        end
    end
endmodule
